// File: rtl/pl_dbg_pkg.sv
// pl_dbg_pkg: shared definitions for the pipelined-CPU debug controller.
//   - dbg_state_e : run-control state encoding (HALT=0, RUN=1, STEP=2, SCAN=3)
//   - DefDw/DefAw : default data/PC width and debug register address width
//   - TraceMacro  : name of the build macro that enables the PC trace buffer
//   - TraceEn     : 1 when PL_DEBUG_TRACE_EN is defined, else 0
package pl_dbg_pkg;

    typedef enum logic [1:0] {
        StHalt = 2'd0,
        StRun  = 2'd1,
        StStep = 2'd2,
        StScan = 2'd3
    } dbg_state_e;

    localparam int unsigned DefDw = 32;
    localparam int unsigned DefAw = 8;

    localparam string TraceMacro = "PL_DEBUG_TRACE_EN";

`ifdef PL_DEBUG_TRACE_EN
    localparam bit TraceEn = 1'b1;
`else
    localparam bit TraceEn = 1'b0;
`endif

endpackage

// File: rtl/pl_trace_buf.sv
// pl_trace_buf: circular PC trace buffer, built only with PL_DEBUG_TRACE_EN.
// Ports:
//   clk, rst      : clock, synchronous active-low reset (clears pointer and count)
//   wr_en/wr_data : capture one entry; the oldest entry is overwritten when full
//   rd_idx        : read index relative to the oldest entry (0 = oldest)
//   rd_data       : entry at rd_idx (combinational read)
//   count         : number of valid entries, saturating at DEPTH
module pl_trace_buf #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DW-1:0]              wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [DW-1:0]              rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (count != CW'(DEPTH)) begin
                count <= count + 1'b1;
            end
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Oldest entry sits at wr_ptr - count; when full the truncated count is 0
    // and the oldest entry is the one about to be overwritten.
    assign rd_ptr  = wr_ptr - PW'(count) + rd_idx;
    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/pl_debug_ctrl.sv
// pl_debug_ctrl: run-control and debug readout unit for the pipelined CPU.
// Optional feature macro: PL_DEBUG_TRACE_EN (adds a DEPTH-entry PC trace buffer
// that is dumped after the register sweep).
// Ports:
//   clk, rst                      : clock, synchronous active-low reset
//   cmd_run/halt/step/scan        : one-cycle command pulses
//   bp_en, bp_addr                : PC breakpoint
//   pc_out, rf_data               : CPU fetch PC and debug register read data
//   cpu_en                        : CPU clock enable (combinational)
//   m_rf_addr                     : debug register address
//   out_valid/ready/data/idx/trace: readout stream
//   halted, bp_hit                : status
module pl_debug_ctrl
    import pl_dbg_pkg::*;
#(
    parameter int unsigned DW    = DefDw,
    parameter int unsigned AW    = DefAw,
    parameter int unsigned NREG  = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_run,
    input  logic          cmd_halt,
    input  logic          cmd_step,
    input  logic          cmd_scan,
    input  logic          bp_en,
    input  logic [DW-1:0] bp_addr,
    input  logic [DW-1:0] pc_out,
    input  logic [DW-1:0] rf_data,
    output logic          cpu_en,
    output logic [AW-1:0] m_rf_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_idx,
    output logic          out_trace,
    output logic          halted,
    output logic          bp_hit
);

    localparam int unsigned   CW      = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] LastReg = AW'(NREG - 1);

    dbg_state_e    state_q;
    logic          bp_mask_q;
    logic          bp_hit_q;
    logic [AW-1:0] idx_q;
    logic          trace_ph_q;   // 1 while dumping trace entries
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic [AW-1:0] out_idx_q;
    logic          out_trace_q;

    logic          bp_match;
    logic [CW-1:0] tr_count;
    logic [DW-1:0] tr_data;
    logic          tr_avail;
    logic          tr_last;

`ifdef PL_DEBUG_TRACE_EN
    localparam int unsigned PW = $clog2(DEPTH);

    pl_trace_buf #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_trace_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cpu_en),
        .wr_data (pc_out),
        .rd_idx  (PW'(idx_q)),
        .rd_data (tr_data),
        .count   (tr_count)
    );
`else
    assign tr_count = '0;
    assign tr_data  = '0;
`endif

    assign tr_avail = (tr_count != '0);
    assign tr_last  = ((32'(idx_q) + 32'd1) == 32'(tr_count));

    // The mask suppresses the match on the first RUN cycle so a resume from
    // the breakpoint PC steps past it.
    assign bp_match = bp_en && (pc_out == bp_addr) && !bp_mask_q;

    always_comb begin
        cpu_en = 1'b0;
        case (state_q)
            StStep:  cpu_en = 1'b1;
            StRun:   cpu_en = !bp_match;
            default: cpu_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StHalt;
            bp_mask_q   <= 1'b0;
            bp_hit_q    <= 1'b0;
            idx_q       <= '0;
            trace_ph_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_trace_q <= 1'b0;
        end else begin
            case (state_q)
                StHalt: begin
                    if (cmd_halt) begin
                        state_q <= StHalt;
                    end else if (cmd_step) begin
                        state_q  <= StStep;
                        bp_hit_q <= 1'b0;
                    end else if (cmd_run) begin
                        state_q   <= StRun;
                        bp_mask_q <= 1'b1;
                        bp_hit_q  <= 1'b0;
                    end else if (cmd_scan) begin
                        state_q     <= StScan;
                        idx_q       <= '0;
                        trace_ph_q  <= 1'b0;
                        out_valid_q <= 1'b0;
                        out_trace_q <= 1'b0;
                    end
                end
                StStep: begin
                    state_q <= StHalt;
                end
                StRun: begin
                    bp_mask_q <= 1'b0;
                    if (bp_match) begin
                        bp_hit_q <= 1'b1;
                        state_q  <= StHalt;
                    end else if (cmd_halt) begin
                        state_q <= StHalt;
                    end
                end
                StScan: begin
                    if (cmd_halt) begin
                        state_q     <= StHalt;
                        out_valid_q <= 1'b0;
                        idx_q       <= '0;
                        trace_ph_q  <= 1'b0;
                    end else if (!out_valid_q) begin
                        // Address cycle: capture the word selected by idx_q.
                        out_valid_q <= 1'b1;
                        out_data_q  <= trace_ph_q ? tr_data : rf_data;
                        out_idx_q   <= idx_q;
                        out_trace_q <= trace_ph_q;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (!trace_ph_q && (idx_q == LastReg)) begin
                            idx_q <= '0;
                            if (tr_avail) begin
                                trace_ph_q <= 1'b1;
                            end else begin
                                state_q <= StHalt;
                            end
                        end else if (trace_ph_q && tr_last) begin
                            idx_q      <= '0;
                            trace_ph_q <= 1'b0;
                            state_q    <= StHalt;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StHalt;
            endcase
        end
    end

    assign m_rf_addr = (state_q == StScan && !trace_ph_q) ? idx_q : '0;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_trace = TraceEn ? out_trace_q : 1'b0;
    assign halted    = (state_q == StHalt);
    assign bp_hit    = bp_hit_q;

endmodule

// File: doc/pl_debug_ctrl.md
Name: pl_debug_ctrl

Overview:
- Synthesizable run-control and debug-readout unit for the pipelined CPU (cpu_pl).
- Replaces the fixed free-running clock/reset and the hard-wired m_rf_addr=0 used in simulation.
- Gates CPU progress through a clock enable and supports run, halt, single-step and a PC breakpoint.
- When halted, sweeps m_rf_addr across the register file and streams the values over a valid/ready port. An optional PC trace buffer is dumped on the same port.

Parameters:
DW, 32, data/PC width
AW, 8, m_rf_addr width (matches the CPU debug address)
NREG, 32, registers swept per scan (1..2^AW)
DEPTH, 16, trace buffer entries (power of two; used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
cmd_run  in  1  one-cycle pulse: start free run
cmd_halt  in  1  one-cycle pulse: stop / abort
cmd_step  in  1  one-cycle pulse: advance exactly one CPU cycle
cmd_scan  in  1  one-cycle pulse: start readout
bp_en  in  1  breakpoint enable
bp_addr  in  DW  breakpoint PC
pc_out  in  DW  CPU fetch PC
rf_data  in  DW  CPU debug register read data (asynchronous read of m_rf_addr)
cpu_en  out  1  CPU clock enable
m_rf_addr  out  AW  debug register address
out_valid  out  1  readout word valid
out_ready  in  1  readout consumer ready
out_data  out  DW  readout word
out_idx  out  AW  register index, or trace entry index
out_trace  out  1  1 = word is a trace entry
halted  out  1  state is HALT
bp_hit  out  1  sticky breakpoint flag

Behaviour:
- Reset (rst==0 at a clk edge): state=HALT, m_rf_addr=0, out_valid=0, out_idx=0, out_trace=0, bp_hit=0, bp_mask=0, trace count=0.
- States: HALT, RUN, STEP, SCAN.
- HALT command priority: cmd_halt > cmd_step > cmd_run > cmd_scan.
  - cmd_step -> STEP.
  - cmd_run -> RUN and sets bp_mask=1.
  - cmd_scan -> SCAN with idx=0.
  - Commands arriving while not in HALT are ignored, except cmd_halt.
- cpu_en is combinational:
  - STEP: cpu_en=1.
  - RUN: cpu_en = !(bp_en && pc_out==bp_addr && !bp_mask).
  - All other states: cpu_en=0.
- STEP: lasts exactly one cycle, then HALT. The breakpoint is ignored during STEP.
- RUN:
  - bp_mask clears after the first RUN cycle, so resuming from a breakpoint PC advances past it.
  - On a breakpoint match, cpu_en=0 in that same cycle. The CPU therefore holds with pc_out==bp_addr. Next state is HALT and bp_hit is set to 1.
  - cmd_halt: next state HALT. The CPU still advances in the cycle the pulse is seen.
- bp_hit clears on cmd_run or cmd_step.
- SCAN:
  - m_rf_addr = idx. out_data = rf_data, registered one cycle after the address is driven.
  - out_valid asserts once the data is registered. out_data, out_idx and out_trace hold stable until out_valid && out_ready.
  - On a handshake, idx increments. After the handshake on idx==NREG-1: the trace dump follows if enabled; otherwise next state is HALT and m_rf_addr returns to 0.
  - Sustained out_ready yields one word every 2 cycles (address cycle + valid cycle).
  - cmd_halt during SCAN aborts: out_valid drops next cycle and the state returns to HALT. This is the only permitted valid withdrawal.
- Simultaneous events: a breakpoint match and cmd_halt in the same RUN cycle both lead to HALT; bp_hit is set.
- Reset mid-SCAN or mid-RUN: immediate return to reset values. The trace contents become don't-care.

Optional Feature:
- Macro: PL_DEBUG_TRACE_EN.
- With the macro defined:
  - A DEPTH-entry circular buffer captures pc_out on every cycle where cpu_en==1.
  - When full, the oldest entry is overwritten. The count saturates at DEPTH.
  - After the register sweep, SCAN streams min(count, DEPTH) entries, oldest to newest, with out_trace=1 and out_idx=0..n-1. Same handshake and 2-cycle cadence as the register sweep.
  - The dump is non-destructive.
- Without the macro: no buffer is built, out_trace is tied to 0, and SCAN ends after the register sweep.

Decomposition:
- Package pl_dbg_pkg holds:
  - the state encodings (HALT=2'd0, RUN=2'd1, STEP=2'd2, SCAN=2'd3);
  - defaults DW=32 and AW=8;
  - the macro name.
- Sub-module pl_trace_buf (only under PL_DEBUG_TRACE_EN): circular buffer with write pointer, saturating count and an oldest-first read index.

Test Plan:
- Reset, then cmd_step three times with the CPU at pc 0x0 -> cpu_en is high for exactly 3 cycles total; pc_out=0xC; halted=1.
- bp_en=1, bp_addr=0x20, cmd_run -> halt with pc_out==0x20 and bp_hit=1. A second cmd_run -> pc advances to 0x24 or beyond, and no re-halt at 0x20.
- Preload x1=5, x2=7, NREG=32, out_ready=1, cmd_scan -> 32 words with out_idx 0..31 and data[1]=5, data[2]=7; 64 cycles; then HALT with m_rf_addr=0.
- SCAN with out_ready=0 for 10 cycles at idx=3 -> out_data/out_idx stable; no increment; resumes when ready rises.
- cmd_halt at idx=10 during SCAN -> out_valid=0 next cycle, HALT; a fresh cmd_scan restarts at idx=0.
- PL_DEBUG_TRACE_EN, DEPTH=16, run 20 enabled cycles from pc 0, then scan -> after 32 register words, 16 trace words 0x10..0x4C with out_trace=1.
